pwm_ramp_ctrl: RTL and testbench
================================

Name: pwm_ramp_ctrl

Overview:
Duty-cycle sequencer for the triangle-carrier PWM path. It sits between software/host control and the carrier comparator. It accepts target duty values over a valid/ready handshake and applies them only at carrier valleys, so the compare value never changes mid-period. It ramps duty toward the target by a fixed step per carrier period (soft start / soft stop) and drives the compare value consumed by the comparator.

Parameters:
W, 8, width of carrier count, duty and target (carrier period spans 0..2^W-1..0)
RAMP_STEP, 1, duty change per carrier period while ramping; 1..2^W-1

Ports:
clk  input  1  system clock
nrst  input  1  reset, asynchronous, active-low
tick  input  1  carrier advance strobe (same enable that steps the up/down carrier counter)
carrier  input  W  current carrier counter value
tgt_valid  input  1  target duty offered
tgt_data  input  W  target duty value
tgt_ready  output  1  target can be accepted this cycle
start  input  1  single-cycle request to begin ramping from 0
stop  input  1  single-cycle request to ramp down to 0 and turn off
duty  output  W  active compare value (comparator output = carrier < duty)
busy  output  1  high whenever state != OFF
state  output  2  OFF=0, RAMP=1, HOLD=2, STOP_RAMP=3
period_evt  output  1  one-cycle pulse, registered, one clk after each valley

Behaviour:
- Reset (nrst low, async): state=OFF, duty=0, target=0, pending empty, period_evt=0; tgt_ready=1, busy=0 after reset release (and while in reset).
- Valley = tick high AND carrier==0, sampled on clk rising edge. All duty/target/state updates driven by valleys happen on that edge; new duty visible the following cycle.
- Handshake: transfer when tgt_valid & tgt_ready on a rising edge. tgt_ready = (state != STOP_RAMP) & pending empty. Accepted value goes to pending register; pending moves into target at the next valley (pending then empties). tgt_data is don't-care when tgt_valid low. Valid may drop without transfer.
- Valley + accept in the same cycle: the pending value promoted at that valley is the previously held one; the new value becomes pending. Accept with pending empty at a valley: value goes to pending, not to target, that cycle.
- OFF: duty held 0. Targets accepted and promoted normally (preload). start -> RAMP next cycle. stop ignored.
- RAMP: at each valley, step toward target: if |target-duty| <= RAMP_STEP then duty=target, else duty +/- RAMP_STEP. Compute in W+1 bits; no wrap, never overshoot, never below 0 or above 2^W-1. When duty==target after the update (or already equal at a valley) -> HOLD.
- HOLD: duty constant. At a valley, if target (after promotion) != duty -> RAMP and the same valley applies the first step.
- stop in RAMP or HOLD -> STOP_RAMP next cycle; pending discarded; target forced 0.
- STOP_RAMP: duty decreases by RAMP_STEP per valley, saturating at 0; when duty reaches 0 -> OFF. start ignored; tgt_ready=0.
- start and stop in the same cycle: stop wins (from OFF: stay OFF). start outside OFF ignored.
- Promoted target of 0 in RAMP/HOLD ramps down to 0 and parks in HOLD (does not go OFF).
- Carrier sampled as given; block does not check carrier legality. Missing valleys stall all ramping, with no timeout.
- Async reset mid-ramp: duty immediately 0, all state cleared.

Test Plan:
- W=8, STEP=16: reset, push target 128 in OFF, pulse start -> duty 16,32,...,128 on successive valleys (8 valleys), state RAMP then HOLD, busy=1.
- HOLD at 128, push target 40 -> at valleys duty 112,96,...,48,40 (last step clipped to 40, no undershoot), then HOLD.
- STEP=16, duty 250 HOLD, push target 255 -> single valley yields 255 (no wrap); push 0 -> ramps to 0 and stays HOLD, busy=1.
- Back-to-back offers 200 then 60 with no valley between -> first accepted, tgt_ready low until next valley, 60 accepted after promotion; final target 60.
- stop at duty 64 with pending 200 -> pending dropped, tgt_ready=0, duty 48,32,16,0, state OFF; start+stop same cycle in OFF -> stays OFF.
- Assert nrst low mid-ramp between clock edges -> duty=0, state=OFF immediately (async); period_evt pulses exactly one clk after each valley, never without tick.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// pwm_ramp_ctrl : valley-synchronous duty sequencer with soft start/stop ramp
// Rev 1.0
// ============================================================================
module pwm_ramp_ctrl #(
  parameter int W         = 8,
  parameter int RAMP_STEP = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         tick,
  input  logic [W-1:0] carrier,
  input  logic         tgt_valid,
  input  logic [W-1:0] tgt_data,
  output logic         tgt_ready,
  input  logic         start,
  input  logic         stop,
  output logic [W-1:0] duty,
  output logic         busy,
  output logic [1:0]   state,
  output logic         period_evt
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  localparam logic [W:0] STEP = (W+1)'(RAMP_STEP);

  state_t       state_q, state_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] target_q, target_d;
  logic [W-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         period_evt_q;

  logic         valley;
  logic         accept;
  logic [W-1:0] tgt_eff;
  logic [W:0]   duty_x, tgt_x, diff_x, step_res, dn_res;

  assign valley    = tick && (carrier == '0);
  assign tgt_ready = (state_q != ST_STOP) && !pend_vld_q;
  assign accept    = tgt_valid && tgt_ready;

  // Widened arithmetic so a step can never wrap past 0 or 2^W-1.
  always_comb begin
    tgt_eff = (valley && pend_vld_q) ? pend_q : target_q;
    duty_x  = {1'b0, duty_q};
    tgt_x   = {1'b0, tgt_eff};
    if (tgt_x >= duty_x) begin
      diff_x   = tgt_x - duty_x;
      step_res = (diff_x <= STEP) ? tgt_x : (duty_x + STEP);
    end else begin
      diff_x   = duty_x - tgt_x;
      step_res = (diff_x <= STEP) ? tgt_x : (duty_x - STEP);
    end
    dn_res = (duty_x > STEP) ? (duty_x - STEP) : '0;
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;

    // Promotion and acceptance are mutually exclusive: accept needs pending empty.
    if (valley && pend_vld_q) begin
      target_d   = pend_q;
      pend_vld_d = 1'b0;
    end
    if (accept) begin
      pend_d     = tgt_data;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      ST_OFF: begin
        duty_d = '0;
        if (start && !stop) state_d = ST_RAMP;
      end
      ST_RAMP, ST_HOLD: begin
        if (stop) begin
          state_d    = ST_STOP;
          target_d   = '0;
          pend_vld_d = 1'b0;
        end else if (valley) begin
          duty_d  = step_res[W-1:0];
          state_d = (step_res == tgt_x) ? ST_HOLD : ST_RAMP;
        end
      end
      ST_STOP: begin
        if (valley) begin
          duty_d = dn_res[W-1:0];
          if (dn_res == '0) state_d = ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_OFF;
      duty_q       <= '0;
      target_q     <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      period_evt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      period_evt_q <= valley;
    end
  end

  assign duty       = duty_q;
  assign busy       = (state_q != ST_OFF);
  assign state      = state_q;
  assign period_evt = period_evt_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pwm_ramp_ctrl : directed checks of pwm_ramp_ctrl with W=8, RAMP_STEP=16
// Rev 1.0
// ============================================================================
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       tick;
  logic [7:0] carrier;
  logic       tgt_valid;
  logic [7:0] tgt_data;
  logic       tgt_ready;
  logic       start;
  logic       stop;
  logic [7:0] duty;
  logic       busy;
  logic [1:0] state;
  logic       period_evt;

  int total = 0;
  int bad   = 0;

  pwm_ramp_ctrl #(.W(8), .RAMP_STEP(16)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .tick       (tick),
    .carrier    (carrier),
    .tgt_valid  (tgt_valid),
    .tgt_data   (tgt_data),
    .tgt_ready  (tgt_ready),
    .start      (start),
    .stop       (stop),
    .duty       (duty),
    .busy       (busy),
    .state      (state),
    .period_evt (period_evt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic valley();
    tick = 1'b1; carrier = 8'd0;
    cyc();
    tick = 1'b0; carrier = 8'd0;
  endtask

  task automatic idle();
    tick = 1'b1; carrier = 8'd9;
    cyc();
    tick = 1'b0; carrier = 8'd0;
  endtask

  task automatic offer(input logic [7:0] v);
    tgt_valid = 1'b1; tgt_data = v;
    cyc();
    tgt_valid = 1'b0;
  endtask

  initial begin
    nrst = 1'b0; tick = 1'b0; carrier = 8'd0;
    tgt_valid = 1'b0; tgt_data = 8'd0; start = 1'b0; stop = 1'b0;
    cyc(); cyc();
    chk("rst_duty",  duty, 0);
    chk("rst_state", state, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", tgt_ready, 1);
    chk("rst_evt",   period_evt, 0);
    nrst = 1'b1;
    cyc();

    // Preload 128 while OFF
    offer(8'd128);
    chk("pend_full_ready", tgt_ready, 0);
    valley();
    chk("evt_after_valley", period_evt, 1);
    chk("off_duty", duty, 0);
    chk("off_state", state, 0);
    chk("ready_after_promo", tgt_ready, 1);
    cyc();
    chk("evt_no_tick", period_evt, 0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_state", state, 1);
    chk("start_busy", busy, 1);
    chk("start_duty", duty, 0);

    for (int k = 1; k <= 8; k++) begin
      valley();
      chk("up_duty", duty, 16 * k);
      chk("up_state", state, (k == 8) ? 2 : 1);
      idle();
      chk("idle_evt", period_evt, 0);
    end

    // Down to 40, last step clipped
    offer(8'd40);
    for (int k = 1; k <= 6; k++) begin
      valley();
      chk("dn40_duty", duty, (k == 6) ? 40 : 128 - 16 * k);
      chk("dn40_state", state, (k == 6) ? 2 : 1);
    end

    // Up to 250, then 255 in a single clipped step
    offer(8'd250);
    for (int k = 1; k <= 14; k++) begin
      valley();
      chk("up250_duty", duty, (k == 14) ? 250 : 40 + 16 * k);
    end
    chk("up250_state", state, 2);
    offer(8'd255);
    valley();
    chk("top_duty", duty, 255);
    chk("top_state", state, 2);

    // Target 0 from RAMP/HOLD parks in HOLD
    offer(8'd0);
    for (int k = 1; k <= 16; k++) begin
      valley();
      chk("to0_duty", duty, (k == 16) ? 0 : 255 - 16 * k);
    end
    chk("to0_state", state, 2);
    chk("to0_busy", busy, 1);

    // Back-to-back offers 200 then 60
    tgt_valid = 1'b1; tgt_data = 8'd200;
    cyc();
    tgt_data = 8'd60;
    chk("b2b_ready_low1", tgt_ready, 0);
    cyc();
    chk("b2b_ready_low2", tgt_ready, 0);
    valley();
    chk("b2b_ready_high", tgt_ready, 1);
    chk("b2b_duty1", duty, 16);
    chk("b2b_state1", state, 1);
    cyc();
    tgt_valid = 1'b0;
    chk("b2b_accept60", tgt_ready, 0);
    valley();
    chk("b2b_duty2", duty, 32);
    valley();
    chk("b2b_duty3", duty, 48);
    valley();
    chk("b2b_duty4", duty, 60);
    chk("b2b_state4", state, 2);
    chk("b2b_ready_end", tgt_ready, 1);

    // Stop at 64 with 200 pending
    offer(8'd64);
    valley();
    chk("at64_duty", duty, 64);
    chk("at64_state", state, 2);
    offer(8'd200);
    chk("pend200_ready", tgt_ready, 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop_state", state, 3);
    chk("stop_ready", tgt_ready, 0);
    tgt_valid = 1'b1; tgt_data = 8'd99;
    cyc();
    tgt_valid = 1'b0;
    chk("stopramp_ready", tgt_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      valley();
      chk("stop_duty", duty, 64 - 16 * k);
      chk("stop_state_k", state, (k == 4) ? 0 : 3);
    end
    chk("off_ready", tgt_ready, 1);
    chk("off_busy", busy, 0);

    // Dropped pending/forced-zero target: restart holds at 0
    start = 1'b1; cyc(); start = 1'b0;
    chk("restart_state", state, 1);
    valley();
    chk("restart_duty", duty, 0);
    chk("restart_hold", state, 2);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("stop0_state", state, 3);
    valley();
    chk("stop0_off", state, 0);
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    chk("start_stop_off", state, 0);
    chk("start_stop_busy", busy, 0);

    // Async reset mid-ramp
    offer(8'd255);
    start = 1'b1; cyc(); start = 1'b0;
    valley();
    chk("ar_duty1", duty, 16);
    valley();
    chk("ar_duty2", duty, 32);
    #2 nrst = 1'b0;
    #1;
    chk("ar_duty0", duty, 0);
    chk("ar_state", state, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", tgt_ready, 1);
    chk("ar_evt", period_evt, 0);
    cyc();
    nrst = 1'b1;
    cyc();
    chk("ar_post_duty", duty, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
